// File: rtl/decrypt_frame_buffer.sv
// Realigns decrypter output with a delayed in_valid, packs bytes into frames and
// streams them from two ping-pong banks. Optional frame XOR port: DECRYPT_FRAME_XOR_EN.
module decrypt_frame_buffer #(
    parameter int N           = 8,
    parameter int FRAME_BYTES = 32,
    parameter int PIPE_LAT    = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         frame_done,
    output logic         overflow
`ifdef DECRYPT_FRAME_XOR_EN
    ,
    output logic [N-1:0] frame_xor
`endif
);

    localparam int IDX_W = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_e;

    logic [PIPE_LAT-1:0] vdly_q, vdly_d;
    logic                byte_valid;
    bank_state_e         bank_q [2];
    bank_state_e         bank_d [2];
    logic [N-1:0]        mem_q  [2][FRAME_BYTES];
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
    logic                frame_done_q, frame_done_d;
    logic                overflow_q, overflow_d;
    logic                rd_xfer, rd_free;
    logic                wr_full, wr_en, wr_last;

    always_comb begin
        vdly_d[0] = in_valid;
        for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            vdly_d[i] = vdly_q[i-1];
        end
    end

    assign byte_valid = vdly_q[PIPE_LAT-1];

    // A bank freed this cycle counts as empty for the incoming byte.
    assign wr_full = (bank_q[wr_bank_q] == BANK_FULL) && !(rd_free && (rd_bank_q == wr_bank_q));
    assign wr_en   = byte_valid && !wr_full;
    assign wr_last = (wr_idx_q == LAST_IDX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vdly_q       <= '0;
            bank_q[0]    <= BANK_EMPTY;
            bank_q[1]    <= BANK_EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            vdly_q       <= vdly_d;
            bank_q[0]    <= bank_d[0];
            bank_q[1]    <= bank_d[1];
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            if (rd_free && (rd_bank_q == 1'(b))) begin
                bank_d[b] = BANK_EMPTY;
            end
            if (wr_en && (wr_bank_q == 1'(b))) begin
                bank_d[b] = wr_last ? BANK_FULL : BANK_FILLING;
            end
        end
        rd_idx_d     = rd_xfer ? (rd_free ? '0 : rd_idx_q + 1'b1) : rd_idx_q;
        rd_bank_d    = rd_bank_q ^ rd_free;
        wr_idx_d     = wr_en ? (wr_last ? '0 : wr_idx_q + 1'b1) : wr_idx_q;
        wr_bank_d    = wr_bank_q ^ (wr_en && wr_last);
        frame_done_d = wr_en && wr_last;
        overflow_d   = overflow_q | (byte_valid && wr_full);
    end

    always_comb begin
        out_valid  = (bank_q[rd_bank_q] == BANK_FULL);
        out_last   = out_valid && (rd_idx_q == LAST_IDX);
        out_data   = mem_q[rd_bank_q][rd_idx_q];
        rd_xfer    = out_valid && out_ready;
        rd_free    = rd_xfer && out_last;
        frame_done = frame_done_q;
        overflow   = overflow_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[wr_bank_q][wr_idx_q] <= data;
        end
    end

`ifdef DECRYPT_FRAME_XOR_EN
    logic [N-1:0] xor_q [2];
    logic [N-1:0] xor_d [2];

    always_comb begin
        for (int unsigned b = 0; b < 2; b++) begin
            xor_d[b] = xor_q[b];
            if (rd_free && (rd_bank_q == 1'(b))) begin
                xor_d[b] = '0;
            end
            if (wr_en && (wr_bank_q == 1'(b))) begin
                xor_d[b] = xor_d[b] ^ data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xor_q[0] <= '0;
            xor_q[1] <= '0;
        end else begin
            xor_q[0] <= xor_d[0];
            xor_q[1] <= xor_d[1];
        end
    end

    assign frame_xor = xor_q[rd_bank_q];
`endif

endmodule

// File: doc/decrypt_frame_buffer.md
Name: decrypt_frame_buffer

Overview:
- Sits directly downstream of the 5-stage decryption pipeline.
- Realigns a per-byte valid with the pipeline's `data` output and assembles decrypted bytes into FRAME_BYTES-byte frames.
- Buffers frames in two ping-pong banks and streams them to the consumer over a valid/ready interface with frame delimiting.
- Absorbs the decrypter's no-stall behaviour; flags overflow when both banks are occupied.

Parameters:
- N, 8: byte/word width; must match the decrypter's N.
- FRAME_BYTES, 32: bytes per frame; power of two, at least 2.
- PIPE_LAT, 5: decrypter latency in cycles from `e_data` sampled to `data` valid; at least 1.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  qualifies `e_data` entering the decrypter this cycle.
- data  in  N  decrypter output (the S5 stage).
- out_valid  out  1  out_data holds a valid byte.
- out_ready  in  1  consumer accepts the byte when out_valid is also high.
- out_data  out  N  current byte of the frame being drained.
- out_last  out  1  high with the final byte (index FRAME_BYTES-1) of a frame.
- frame_done  out  1  one-cycle pulse when a frame finishes filling.
- overflow  out  1  sticky; set when a valid byte is dropped.

Behaviour:
- Reset values: out_valid=0, out_last=0, frame_done=0, overflow=0, out_data=0. Both banks empty, wr_bank=rd_bank=0, wr_idx=rd_idx=0, valid delay line all zero.
- Valid alignment:
  - PIPE_LAT-deep shift register on in_valid; byte_valid is its last tap.
  - byte_valid is high in the cycle the matching byte appears on `data`.
  - Because the delay line is cleared on reset, unreset decrypter contents are never captured.
- Write side (per bank, state EMPTY -> FILLING -> FULL):
  - On byte_valid with bank[wr_bank] not FULL: store `data` at [wr_bank][wr_idx], then increment wr_idx.
  - When wr_idx == FRAME_BYTES-1: wr_idx wraps to 0, bank goes FULL, wr_bank toggles, frame_done pulses in the next cycle.
  - On byte_valid with bank[wr_bank] FULL: byte is dropped, wr_idx holds, overflow sets and stays set until reset.
  - Gaps in in_valid are allowed; a frame can span any number of cycles.
- Read side:
  - out_valid = bank[rd_bank] FULL.
  - out_data = mem[rd_bank][rd_idx], driven from registered storage with no extra latency.
  - out_last = out_valid && rd_idx == FRAME_BYTES-1.
  - A transfer occurs when out_valid && out_ready; rd_idx then increments.
  - A transfer with out_last set: rd_idx wraps to 0, bank[rd_bank] becomes EMPTY, rd_bank toggles.
  - out_valid may not drop while out_ready is low.
- Simultaneous free and write to the same bank: the free takes effect first, so the incoming byte is accepted as index 0 of a new frame. No overflow is flagged.
- Latency: with continuous in_valid starting in cycle 0, the last byte is written in cycle PIPE_LAT+FRAME_BYTES-1 and out_valid first goes high in cycle PIPE_LAT+FRAME_BYTES (37 at defaults).
- Throughput: 1 byte per cycle in and out. With out_ready held high, continuous input never overflows.
- Reset mid-frame: partial frames in both banks are discarded and in-flight delay-line bits are lost. The first in_valid after reset deassertion starts frame index 0.

Optional Feature:
- Macro: DECRYPT_FRAME_XOR_EN.
- When defined:
  - Adds output port frame_xor, width N.
  - Each bank keeps a running XOR of its bytes as they are written, cleared when the bank is freed.
  - frame_xor presents the rd_bank value and is valid while out_valid is high; it is 0 at reset.
- When undefined: port, XOR registers and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then 32 consecutive in_valid with data=i (0..31) at the decrypter output, out_ready=1 → out_valid rises in cycle 37; bytes 0..31 come out in order; out_last only on byte 31; frame_done pulses once; overflow=0.
- 96 consecutive bytes with out_ready=0 → banks fill at bytes 32 and 64; bytes 64..95 are dropped; overflow=1. Raising out_ready then yields frames 0..31 and 32..63 back-to-back with no bubble.
- in_valid toggled every other cycle for 64 bytes, out_ready random 50% → two complete ordered frames, no loss, overflow=0.
- Bank freed (out_last transfer) in the same cycle the first byte of frame 3 arrives for that bank → byte accepted as index 0; overflow stays 0.
- Assert reset at byte 17 of frame 0, then send a full 32-byte frame → only the new frame is output, starting at its byte 0; no stale bytes.
- With DECRYPT_FRAME_XOR_EN defined, frame bytes = 0x01..0x20 → frame_xor = 0x20 throughout the drain.
